// File: rtl/letc_core_csr_seq.sv
// LETC Core CSR access sequencer: round-robin arbitration of explicit CSR requests,
// each carried out as an atomic read-modify-write on the CSR file's read and write ports.
module letc_core_csr_seq #(
   parameter int NUM_REQ = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [2*NUM_REQ-1:0]  req_op_i,
   input  logic [12*NUM_REQ-1:0] req_idx_i,
   input  logic [32*NUM_REQ-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_ill_o,
   output logic                  csr_explicit_ren_o,
   output logic [11:0]           csr_explicit_ridx_o,
   input  logic [31:0]           csr_explicit_rdata_i,
   input  logic                  csr_explicit_rill_i,
   output logic                  csr_explicit_wen_o,
   output logic [11:0]           csr_explicit_widx_o,
   output logic [31:0]           csr_explicit_wdata_o,
   input  logic                  csr_explicit_will_i
);

   localparam int PTR_W = $clog2(NUM_REQ);

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RSP  = 2'd3
   } state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   grant_q;
   logic [1:0]         op_q;
   logic [11:0]        idx_q;
   logic [31:0]        opnd_q;
   logic [31:0]        old_q;
   logic               ill_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_ill_q;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W:0]     cand;
   logic [PTR_W-1:0]   ptr_d;
   logic [1:0]         sel_op;
   logic [11:0]        sel_idx;
   logic [31:0]        sel_wdata;
   logic [NUM_REQ-1:0] ready;
   logic [NUM_REQ-1:0] grant_oh;
   logic [31:0]        wdata_d;
   logic               wr_ill_d;

   function automatic logic [31:0] csr_modify(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] opnd);
      logic [31:0] res;
      case (op)
         OP_RW:   res = opnd;
         OP_RS:   res = old_val | opnd;
         OP_RC:   res = old_val & ~opnd;
         default: res = old_val;
      endcase
      return res;
   endfunction

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_REQ)) begin
            cand = cand - (PTR_W+1)'(NUM_REQ);
         end
         if (!win_found && req_valid_i[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   always_comb begin
      sel_op    = '0;
      sel_idx   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PTR_W'(i)) begin
            sel_op    = req_op_i[2*i +: 2];
            sel_idx   = req_idx_i[12*i +: 12];
            sel_wdata = req_wdata_i[32*i +: 32];
         end
      end
   end

   // Ready is also held low while rst_n is asserted so no requester sees an accept in reset.
   always_comb begin
      ready = '0;
      if (rst_n && (state_q == IDLE) && win_found) begin
         ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      grant_oh = '0;
      grant_oh[grant_q] = 1'b1;
   end

   assign wdata_d  = csr_modify(op_q, old_q, opnd_q);
   assign wr_ill_d = ill_q | csr_explicit_will_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         op_q        <= '0;
         idx_q       <= '0;
         opnd_q      <= '0;
         old_q       <= '0;
         ill_q       <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_ill_q   <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_ill_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  op_q    <= sel_op;
                  idx_q   <= sel_idx;
                  opnd_q  <= sel_wdata;
                  grant_q <= win_idx;
                  ptr_q   <= ptr_d;
                  state_q <= RD;
               end
            end
            RD: begin
               old_q <= csr_explicit_rdata_i;
               ill_q <= csr_explicit_rill_i;
               if (csr_explicit_rill_i || (op_q == OP_READ)) begin
                  state_q     <= RSP;
                  rsp_valid_q <= grant_oh;
                  rsp_rdata_q <= csr_explicit_rill_i ? '0 : csr_explicit_rdata_i;
                  rsp_ill_q   <= csr_explicit_rill_i;
               end else begin
                  state_q <= WR;
               end
            end
            WR: begin
               ill_q       <= wr_ill_d;
               state_q     <= RSP;
               rsp_valid_q <= grant_oh;
               rsp_rdata_q <= wr_ill_d ? '0 : old_q;
               rsp_ill_q   <= wr_ill_d;
            end
            RSP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // CSR port drives decode straight from state so an async reset drops them at once.
   assign csr_explicit_ren_o   = (state_q == RD);
   assign csr_explicit_ridx_o  = (state_q == RD) ? idx_q : '0;
   assign csr_explicit_wen_o   = (state_q == WR);
   assign csr_explicit_widx_o  = (state_q == WR) ? idx_q : '0;
   assign csr_explicit_wdata_o = (state_q == WR) ? wdata_d : '0;

   assign req_ready_o = ready;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_ill_o   = rsp_ill_q;

endmodule

// File: tb/tb_letc_core_csr_seq.sv
// Self-checking bench for letc_core_csr_seq: table-driven single accesses, a reference
// CSR model with a response scoreboard, arbitration and mid-operation reset sequences.
module tb_letc_core_csr_seq;

   localparam int NUM_REQ = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [23:0] req_idx;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_ill;
   logic        ren;
   logic [11:0] ridx;
   logic [31:0] rdata;
   logic        rill;
   logic        wen;
   logic [11:0] widx;
   logic [31:0] wdata;
   logic        will;

   always #5 clk = ~clk;

   letc_core_csr_seq #(.NUM_REQ(NUM_REQ)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid_i          (req_valid),
      .req_ready_o          (req_ready),
      .req_op_i             (req_op),
      .req_idx_i            (req_idx),
      .req_wdata_i          (req_wdata),
      .rsp_valid_o          (rsp_valid),
      .rsp_rdata_o          (rsp_rdata),
      .rsp_ill_o            (rsp_ill),
      .csr_explicit_ren_o   (ren),
      .csr_explicit_ridx_o  (ridx),
      .csr_explicit_rdata_i (rdata),
      .csr_explicit_rill_i  (rill),
      .csr_explicit_wen_o   (wen),
      .csr_explicit_widx_o  (widx),
      .csr_explicit_wdata_o (wdata),
      .csr_explicit_will_i  (will)
   );

   // CSR file model: 0x7FF is unreadable, 0xC00-0xFFF are read-only.
   logic [31:0] csr_mem [4096] = '{default: 32'h0};
   assign rdata = ren ? csr_mem[ridx] : 32'h0;
   assign rill  = ren && (ridx == 12'h7FF);
   assign will  = wen && (widx[11:10] == 2'b11);
   always @(posedge clk) begin
      if (wen && !will) csr_mem[widx] <= wdata;
   end

   typedef struct {
      logic [1:0]  op;
      logic [11:0] idx;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      int          r;
      logic [31:0] rdata;
      logic        ill;
      int          due;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] idx;
      logic [31:0] wd;
      logic [31:0] e_rdata;
      logic        e_ill;
      int          e_lat;
      logic        e_wr;
      logic [31:0] e_wdata;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   exp_t        sb[$];
   req_t        rq0[$];
   req_t        rq1[$];
   int          grants[$];
   logic [31:0] ref_mem [4096] = '{default: 32'h0};
   int          model_ptr = 0;
   int          idle_at = 0;
   int          rd_due = -1;
   int          wr_due = -1;
   int          acc_cyc = 0;
   logic [11:0] rd_idx, wr_idx;
   logic [31:0] wr_data;
   logic        wr_ill;
   logic        wr_commit = 1'b0;
   bit          acc0, acc1, acc_seen, rsp_seen, wen_seen;
   logic [31:0] last_rdata, last_wdata;
   logic        last_ill;
   int          last_lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      req_valid = {rq1.size() > 0, rq0.size() > 0};
      req_op    = '0;
      req_idx   = '0;
      req_wdata = '0;
      if (rq0.size() > 0) begin
         req_op[1:0]     = rq0[0].op;
         req_idx[11:0]   = rq0[0].idx;
         req_wdata[31:0] = rq0[0].wd;
      end
      if (rq1.size() > 0) begin
         req_op[3:2]      = rq1[0].op;
         req_idx[23:12]   = rq1[0].idx;
         req_wdata[63:32] = rq1[0].wd;
      end
   endtask

   task automatic model_accept(input int r);
      req_t        q;
      logic [31:0] old, nv;
      logic        ir, iw;
      exp_t        e;
      q = (r == 0) ? rq0[0] : rq1[0];
      old = ref_mem[q.idx];
      ir = (q.idx == 12'h7FF);
      e.r = r;
      acc_cyc = cyc;
      acc_seen = 1'b1;
      grants.push_back(r);
      rd_due = cyc + 1;
      rd_idx = q.idx;
      if (ir || q.op == 2'b00) begin
         e.ill   = ir;
         e.rdata = ir ? 32'h0 : old;
         e.due   = cyc + 2;
      end else begin
         case (q.op)
            2'b01:   nv = q.wd;
            2'b10:   nv = old | q.wd;
            default: nv = old & ~q.wd;
         endcase
         iw = (q.idx[11:10] == 2'b11);
         wr_due  = cyc + 2;
         wr_idx  = q.idx;
         wr_data = nv;
         wr_ill  = iw;
         e.ill   = iw;
         e.rdata = iw ? 32'h0 : old;
         e.due   = cyc + 3;
      end
      sb.push_back(e);
      idle_at = e.due + 1;
      model_ptr = (r + 1) % NUM_REQ;
      if (r == 0) acc0 = 1'b1;
      else acc1 = 1'b1;
   endtask

   // One clock: checks at the falling edge, model commit at the rising edge, then new drive.
   task automatic tick();
      logic [1:0] exp_rdy, oh;
      int         w;
      exp_t       e;
      w = 0;
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_ready", 32'(req_ready), 32'h0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_rsp_rdata", rsp_rdata, 32'h0);
         chk("rst_rsp_ill", 32'(rsp_ill), 32'h0);
         chk("rst_ren", 32'(ren), 32'h0);
         chk("rst_ridx", 32'(ridx), 32'h0);
         chk("rst_wen", 32'(wen), 32'h0);
         chk("rst_widx", 32'(widx), 32'h0);
         chk("rst_wdata", wdata, 32'h0);
         sb.delete();
         rd_due = -1;
         wr_due = -1;
         wr_commit = 1'b0;
         model_ptr = 0;
         idle_at = 0;
         acc0 = 1'b0;
         acc1 = 1'b0;
      end else begin
         exp_rdy = 2'b00;
         if (cyc >= idle_at && req_valid != 2'b00) begin
            w = req_valid[model_ptr] ? model_ptr : 1 - model_ptr;
            exp_rdy = (w == 0) ? 2'b01 : 2'b10;
         end
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (exp_rdy != 2'b00) model_accept(w);
         if (cyc == rd_due) begin
            chk("ren", 32'(ren), 32'h1);
            chk("ridx", 32'(ridx), 32'(rd_idx));
         end else begin
            chk("ren_idle", 32'(ren), 32'h0);
         end
         if (cyc == wr_due) begin
            chk("wen", 32'(wen), 32'h1);
            chk("widx", 32'(widx), 32'(wr_idx));
            chk("wdata", wdata, wr_data);
            wen_seen = 1'b1;
            last_wdata = wdata;
            wr_commit = !wr_ill;
         end else begin
            chk("wen_idle", 32'(wen), 32'h0);
         end
         chk("ren_wen_overlap", 32'(ren & wen), 32'h0);
         if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               e = sb.pop_front();
               oh = (e.r == 0) ? 2'b01 : 2'b10;
               chk("rsp_valid", 32'(rsp_valid), 32'(oh));
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_ill", 32'(rsp_ill), 32'(e.ill));
               chk("rsp_cycle", 32'(cyc), 32'(e.due));
               rsp_seen = 1'b1;
               last_rdata = rsp_rdata;
               last_ill = rsp_ill;
               last_lat = cyc - acc_cyc;
            end
         end else begin
            chk("rsp_rdata_idle", rsp_rdata, 32'h0);
            chk("rsp_ill_idle", 32'(rsp_ill), 32'h0);
            if (sb.size() > 0 && cyc > sb[0].due) begin
               chk("rsp_timeout", 32'(cyc), 32'(sb[0].due));
               sb.delete(0);
            end
         end
      end
      @(posedge clk);
      if (rst_n && wr_commit) ref_mem[wr_idx] = wr_data;
      wr_commit = 1'b0;
      cyc++;
      #1;
      if (acc0) rq0.delete(0);
      if (acc1) rq1.delete(0);
      acc0 = 1'b0;
      acc1 = 1'b0;
      drive();
   endtask

   task automatic run_idle(input int budget);
      int n;
      n = 0;
      while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0 || cyc < idle_at) && n < budget) begin
         tick();
         n++;
      end
      chk("drain", 32'(rq0.size() + rq1.size() + sb.size()), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[14];
      vt[0]  = '{2'b01, 12'h340, 32'h1234_5678, 32'h0000_0000, 1'b0, 3, 1'b1, 32'h1234_5678};
      vt[1]  = '{2'b01, 12'h340, 32'hA5A5_0000, 32'h1234_5678, 1'b0, 3, 1'b1, 32'hA5A5_0000};
      vt[2]  = '{2'b00, 12'h340, 32'hDEAD_BEEF, 32'hA5A5_0000, 1'b0, 2, 1'b0, 32'h0};
      vt[3]  = '{2'b01, 12'h300, 32'h0000_00F0, 32'h0000_0000, 1'b0, 3, 1'b1, 32'h0000_00F0};
      vt[4]  = '{2'b10, 12'h300, 32'h0000_000F, 32'h0000_00F0, 1'b0, 3, 1'b1, 32'h0000_00FF};
      vt[5]  = '{2'b11, 12'h300, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 3, 1'b1, 32'h0000_000F};
      vt[6]  = '{2'b10, 12'h300, 32'h0000_0000, 32'h0000_000F, 1'b0, 3, 1'b1, 32'h0000_000F};
      vt[7]  = '{2'b11, 12'h300, 32'h0000_000E, 32'h0000_000F, 1'b0, 3, 1'b1, 32'h0000_0001};
      vt[8]  = '{2'b00, 12'h7FF, 32'h0000_0000, 32'h0000_0000, 1'b1, 2, 1'b0, 32'h0};
      vt[9]  = '{2'b01, 12'h7FF, 32'h1111_1111, 32'h0000_0000, 1'b1, 2, 1'b0, 32'h0};
      vt[10] = '{2'b01, 12'hC00, 32'h0000_0055, 32'h0000_0000, 1'b1, 3, 1'b1, 32'h0000_0055};
      vt[11] = '{2'b00, 12'hC00, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 1'b0, 32'h0};
      vt[12] = '{2'b10, 12'hC01, 32'h0000_0003, 32'h0000_0000, 1'b1, 3, 1'b1, 32'h0000_0003};
      vt[13] = '{2'b00, 12'h300, 32'h0000_0000, 32'h0000_0001, 1'b0, 2, 1'b0, 32'h0};

      // Reset with both requesters valid: everything quiet, then requester 0 first.
      rst_n = 1'b0;
      rq0.push_back('{2'b00, 12'h001, 32'h0});
      rq1.push_back('{2'b00, 12'h002, 32'h0});
      drive();
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 32'(req_ready), 32'h1);
      run_idle(40);
      chk("reset_grant_count", 32'(grants.size()), 32'd2);
      if (grants.size() == 2) begin
         chk("reset_grant0", 32'(grants[0]), 32'd0);
         chk("reset_grant1", 32'(grants[1]), 32'd1);
      end

      for (int i = 0; i < 14; i++) begin
         rsp_seen = 1'b0;
         wen_seen = 1'b0;
         last_wdata = 32'h0;
         rq0.push_back('{vt[i].op, vt[i].idx, vt[i].wd});
         drive();
         run_idle(20);
         chk($sformatf("v%0d_rsp_seen", i), 32'(rsp_seen), 32'h1);
         chk($sformatf("v%0d_rdata", i), last_rdata, vt[i].e_rdata);
         chk($sformatf("v%0d_ill", i), 32'(last_ill), 32'(vt[i].e_ill));
         chk($sformatf("v%0d_latency", i), 32'(last_lat), 32'(vt[i].e_lat));
         chk($sformatf("v%0d_wrote", i), 32'(wen_seen), 32'(vt[i].e_wr));
         if (vt[i].e_wr) chk($sformatf("v%0d_wdata", i), last_wdata, vt[i].e_wdata);
      end
      chk("csr_300_final", csr_mem[12'h300], 32'h0000_0001);
      chk("csr_c00_readonly", csr_mem[12'hC00], 32'h0000_0000);

      // Reset while the write is on the bus: write and response are abandoned.
      acc_seen = 1'b0;
      rq0.push_back('{2'b01, 12'h340, 32'hFFFF_0000});
      drive();
      for (int n = 0; n < 10 && !acc_seen; n++) tick();
      chk("midop_accept", 32'(acc_seen), 32'h1);
      tick();
      chk("midop_wen_before", 32'(wen), 32'h1);
      chk("midop_wdata_before", wdata, 32'hFFFF_0000);
      rst_n = 1'b0;
      #1;
      chk("midop_wen_dropped", 32'(wen), 32'h0);
      chk("midop_no_rsp", 32'(rsp_valid), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("midop_csr_kept", csr_mem[12'h340], 32'hA5A5_0000);

      // Both requesters valid back to back: grants alternate starting with 0.
      grants.delete();
      rq0.push_back('{2'b10, 12'h345, 32'h0000_0001});
      rq0.push_back('{2'b00, 12'h345, 32'h0});
      rq0.push_back('{2'b11, 12'h345, 32'h0000_0001});
      rq1.push_back('{2'b10, 12'h345, 32'h0000_0002});
      rq1.push_back('{2'b00, 12'h345, 32'h0});
      rq1.push_back('{2'b01, 12'h345, 32'h0000_0080});
      drive();
      run_idle(60);
      chk("arb_grant_count", 32'(grants.size()), 32'd6);
      for (int i = 0; i < grants.size(); i++) begin
         chk($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));
      end
      chk("arb_csr_final", csr_mem[12'h345], 32'h0000_0080);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
